// File: rtl/axis_width_pkg.sv
// ---------------------------------------------------------------------------
// axis_width_pkg
//   Shared lane-ordering helpers for the AXI-Stream width converters
//   (upsizer / downsizer). Lane i of a wide word lives at
//   bits DATA_WIDTH*i +: DATA_WIDTH, and lane 0 is the first narrow beat.
//
//   MAX_LANES     widest lane count the helpers support
//   lane_mask_t   per-lane mask sized for MAX_LANES
//   lane_idx_w()  width of a lane index for a given lane count
//   leading_keep  contiguous-from-lane-0 valid mask, lane 0 forced valid
// ---------------------------------------------------------------------------
package axis_width_pkg;

  localparam int MAX_LANES = 64;

  typedef logic [MAX_LANES-1:0] lane_mask_t;

  // Width of a lane index; never narrower than one bit.
  function automatic int lane_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Only the leading run of kept lanes is honoured: once a lane is dropped,
  // every lane above it is dropped too. Lane 0 always carries data.
  function automatic lane_mask_t leading_keep(input lane_mask_t keep);
    lane_mask_t mask;
    mask    = '0;
    mask[0] = 1'b1;
    for (int i = 1; i < MAX_LANES; i++) begin
      mask[i] = mask[i-1] & keep[i];
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_downsizer.sv
// ---------------------------------------------------------------------------
// axis_downsizer
//   Narrowing AXI-Stream width converter. Accepts one wide word of
//   DATA_RATIO lanes and emits its valid lanes, lane 0 first, as
//   consecutive DATA_WIDTH beats. The last kept lane of a word carrying
//   tlast is marked with m_axis_tlast.
//
//   aclk           clock
//   areset         asynchronous active-low reset
//   s_axis_*       wide input stream (tdata, tkeep per lane, tvalid, tlast,
//                  tready)
//   m_axis_*       narrow output stream (tdata, tvalid, tlast, tready)
//
//   Two states, implied by valid_q: IDLE (nothing held) and BUSY (a word is
//   being unpacked). s_axis_tready is combinational so a new word can be
//   loaded in the same cycle the final beat of the previous one leaves,
//   giving one narrow beat per cycle with no bubble between words.
// ---------------------------------------------------------------------------
module axis_downsizer
  import axis_width_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DATA_RATIO   = 8,
  parameter int S_DATA_WIDTH = DATA_RATIO * DATA_WIDTH,
  parameter int M_DATA_WIDTH = DATA_WIDTH
) (
  input  logic                    aclk,
  input  logic                    areset,

  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [DATA_RATIO-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,

  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  localparam int                    LANE_IDX_W = lane_idx_w(DATA_RATIO);
  localparam logic [LANE_IDX_W-1:0] LAST_IDX   = LANE_IDX_W'(DATA_RATIO - 1);

  logic [S_DATA_WIDTH-1:0] data_q;
  logic [DATA_RATIO-1:0]   keep_q;
  logic                    last_q;
  logic                    valid_q;
  logic [LANE_IDX_W-1:0]   idx;

  logic [DATA_RATIO-1:0]   keep_eff;
  logic [DATA_RATIO-1:0]   keep_above;
  logic                    final_beat;
  logic                    s_hs;
  logic                    m_hs;

  // Effective keep captured on load: leading run only, lane 0 always valid.
  assign keep_eff = DATA_RATIO'(leading_keep(lane_mask_t'(s_axis_tkeep)));

  // keep_above[i] is the keep bit of lane i+1; the top lane reads a zero,
  // so the lookahead never indexes past the word.
  assign keep_above = keep_q >> 1;
  assign final_beat = (idx == LAST_IDX) || !keep_above[idx];

  assign m_hs = valid_q && m_axis_tready;
  assign s_axis_tready = !valid_q || (m_axis_tready && final_beat);
  assign s_hs = s_axis_tvalid && s_axis_tready;

  assign m_axis_tdata  = data_q[DATA_WIDTH*idx +: DATA_WIDTH];
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = valid_q && last_q && final_beat;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      idx     <= '0;
    end else if (s_hs) begin
      // Covers both IDLE loads and the BUSY final-beat reload: s_hs can only
      // occur when nothing is held or the final beat is leaving.
      data_q  <= s_axis_tdata;
      keep_q  <= keep_eff;
      last_q  <= s_axis_tlast;
      valid_q <= 1'b1;
      idx     <= '0;
    end else if (m_hs) begin
      if (final_beat) begin
        valid_q <= 1'b0;
        idx     <= '0;
      end else begin
        idx <= idx + LANE_IDX_W'(1);
      end
    end
  end

endmodule
